// File: rtl/regfile_seq.sv
// Sequencer that fetches two operands and retires writeback/next-PC through a
// single shared register-file port.
module regfile_seq #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32,
  parameter int PC_ADDR    = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [4:0]            req_rs1,
  input  logic [4:0]            req_rs2,
  output logic                  op_valid,
  input  logic                  op_ready,
  output logic [DATA_WIDTH-1:0] op_rs1_val,
  output logic [DATA_WIDTH-1:0] op_rs2_val,
  input  logic                  wb_valid,
  output logic                  wb_ready,
  input  logic                  wb_en,
  input  logic [4:0]            wb_rd,
  input  logic [DATA_WIDTH-1:0] wb_data,
  input  logic [DATA_WIDTH-1:0] wb_pc,
  output logic [ADDR_WIDTH-1:0] rf_addr,
  output logic                  rf_wen,
  output logic                  rf_ren,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  input  logic [DATA_WIDTH-1:0] rf_rdata,
  output logic                  busy
);

  typedef enum logic [2:0] {IDLE, RD1, RD2, CAP2, OPV, WBW, WRD, WPC} state_t;

  state_t                state, state_nxt;
  logic [4:0]            rs1_q, rs2_q, rd_q;
  logic                  wen_q;
  logic [DATA_WIDTH-1:0] rs1_val, rs2_val, wdata_q, pc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
      wen_q   <= 1'b0;
      rs1_val <= '0;
      rs2_val <= '0;
      wdata_q <= '0;
      pc_q    <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && req_valid) begin
        rs1_q <= req_rs1;
        rs2_q <= req_rs2;
      end
      // Read data lags rf_ren by one cycle; x0 always reads as zero.
      if (state == RD2)  rs1_val <= (rs1_q == 5'd0) ? '0 : rf_rdata;
      if (state == CAP2) rs2_val <= (rs2_q == 5'd0) ? '0 : rf_rdata;
      if (state == WBW && wb_valid) begin
        wen_q   <= wb_en;
        rd_q    <= wb_rd;
        wdata_q <= wb_data;
        pc_q    <= wb_pc;
      end
    end
  end

  // While rst is high every output is forced quiet, so a write in flight is dropped.
  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    op_valid  = 1'b0;
    wb_ready  = 1'b0;
    rf_addr   = '0;
    rf_wen    = 1'b0;
    rf_ren    = 1'b0;
    rf_wdata  = '0;
    busy      = 1'b0;
    if (!rst) begin
      busy = (state != IDLE);
      case (state)
        IDLE: begin
          req_ready = 1'b1;
          if (req_valid) state_nxt = RD1;
        end
        RD1: begin
          rf_ren    = 1'b1;
          rf_addr   = ADDR_WIDTH'(rs1_q);
          state_nxt = RD2;
        end
        RD2: begin
          rf_ren    = 1'b1;
          rf_addr   = ADDR_WIDTH'(rs2_q);
          state_nxt = CAP2;
        end
        CAP2: state_nxt = OPV;
        OPV: begin
          op_valid = 1'b1;
          if (op_ready) state_nxt = WBW;
        end
        WBW: begin
          wb_ready = 1'b1;
          if (wb_valid) state_nxt = (wb_en && wb_rd != 5'd0) ? WRD : WPC;
        end
        WRD: begin
          rf_wen    = 1'b1;
          rf_addr   = ADDR_WIDTH'(rd_q);
          rf_wdata  = wdata_q;
          state_nxt = WPC;
        end
        WPC: begin
          rf_wen    = 1'b1;
          rf_addr   = ADDR_WIDTH'(PC_ADDR);
          rf_wdata  = pc_q;
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign op_rs1_val = rst ? '0 : rs1_val;
  assign op_rs2_val = rst ? '0 : rs2_val;

endmodule

// File: tb/tb_regfile_seq.sv
// Directed bench for regfile_seq with a one-cycle-latency register-file model.
module tb_regfile_seq;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [4:0]  req_rs1, req_rs2;
  logic        op_valid, op_ready;
  logic [31:0] op_rs1_val, op_rs2_val;
  logic        wb_valid, wb_ready, wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data, wb_pc;
  logic [5:0]  rf_addr;
  logic        rf_wen, rf_ren;
  logic [31:0] rf_wdata, rf_rdata;
  logic        busy;
  logic        preload;
  logic [31:0] mem [64];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_seq dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_rs1(req_rs1), .req_rs2(req_rs2),
    .op_valid(op_valid), .op_ready(op_ready), .op_rs1_val(op_rs1_val), .op_rs2_val(op_rs2_val),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_en(wb_en), .wb_rd(wb_rd),
    .wb_data(wb_data), .wb_pc(wb_pc),
    .rf_addr(rf_addr), .rf_wen(rf_wen), .rf_ren(rf_ren), .rf_wdata(rf_wdata),
    .rf_rdata(rf_rdata), .busy(busy)
  );

  // Register-file model: read data appears the cycle after rf_ren.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
      mem[0] <= 32'hDEAD;
      mem[5] <= 32'h11;
      mem[6] <= 32'h22;
    end else if (rf_wen) begin
      mem[rf_addr] <= rf_wdata;
    end
    if (rf_ren) rf_rdata <= mem[rf_addr];
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet_port(input string tag);
    chk({tag, "_ren"}, rf_ren, 1'b0);
    chk({tag, "_wen"}, rf_wen, 1'b0);
    chk({tag, "_addr"}, rf_addr, 6'd0);
    chk({tag, "_wdata"}, rf_wdata, 32'd0);
  endtask

  // Accepts a request and walks it through to OPV, checking the read sequence.
  task automatic fetch(input string tag, input logic [4:0] a, input logic [4:0] b,
                       input logic [31:0] e1, input logic [31:0] e2);
    req_valid = 1'b1; req_rs1 = a; req_rs2 = b;
    #1;
    chk({tag, "_req_ready"}, req_ready, 1'b1);
    step();
    req_valid = 1'b0; req_rs1 = 5'h1f; req_rs2 = 5'h1f;
    chk({tag, "_rd1_ren"}, rf_ren, 1'b1);
    chk({tag, "_rd1_addr"}, rf_addr, {1'b0, a});
    chk({tag, "_rd1_busy"}, busy, 1'b1);
    chk({tag, "_rd1_req_ready"}, req_ready, 1'b0);
    step();
    chk({tag, "_rd2_ren"}, rf_ren, 1'b1);
    chk({tag, "_rd2_addr"}, rf_addr, {1'b0, b});
    chk({tag, "_rd2_opv"}, op_valid, 1'b0);
    step();
    chk({tag, "_cap2_opv"}, op_valid, 1'b0);
    quiet_port({tag, "_cap2"});
    step();
    chk({tag, "_opv"}, op_valid, 1'b1);
    chk({tag, "_rs1"}, op_rs1_val, e1);
    chk({tag, "_rs2"}, op_rs2_val, e2);
    chk({tag, "_opv_wb_ready"}, wb_ready, 1'b0);
  endtask

  task automatic retire_op(input string tag);
    op_ready = 1'b1;
    step();
    op_ready = 1'b0;
    chk({tag, "_wbw_ready"}, wb_ready, 1'b1);
    chk({tag, "_wbw_opv"}, op_valid, 1'b0);
  endtask

  initial begin
    rst = 1'b1; preload = 1'b1;
    req_valid = 1'b0; req_rs1 = '0; req_rs2 = '0; op_ready = 1'b0;
    wb_valid = 1'b0; wb_en = 1'b0; wb_rd = '0; wb_data = '0; wb_pc = '0;
    step();
    step();
    preload = 1'b0;
    chk("rst_req_ready", req_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_opv", op_valid, 1'b0);
    chk("rst_wb_ready", wb_ready, 1'b0);
    chk("rst_rs1", op_rs1_val, 32'd0);
    chk("rst_rs2", op_rs2_val, 32'd0);
    quiet_port("rst");
    rst = 1'b0;
    #1;
    chk("post_rst_req_ready", req_ready, 1'b1);

    // x5/x6 fetch, stall on op_ready, write rd=7 then PC.
    fetch("a", 5'd5, 5'd6, 32'h11, 32'h22);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("a_stall_opv", op_valid, 1'b1);
      chk("a_stall_rs1", op_rs1_val, 32'h11);
      chk("a_stall_rs2", op_rs2_val, 32'h22);
      quiet_port("a_stall");
    end
    retire_op("a");
    wb_valid = 1'b1; wb_en = 1'b1; wb_rd = 5'd7; wb_data = 32'hABCD; wb_pc = 32'h80000004;
    step();
    wb_valid = 1'b0; wb_en = 1'b0; wb_rd = '0; wb_data = '0; wb_pc = '0;
    chk("a_wrd_wen", rf_wen, 1'b1);
    chk("a_wrd_ren", rf_ren, 1'b0);
    chk("a_wrd_addr", rf_addr, 6'd7);
    chk("a_wrd_wdata", rf_wdata, 32'hABCD);
    step();
    chk("a_wpc_wen", rf_wen, 1'b1);
    chk("a_wpc_addr", rf_addr, 6'd32);
    chk("a_wpc_wdata", rf_wdata, 32'h80000004);
    step();
    chk("a_idle_busy", busy, 1'b0);
    chk("a_idle_req_ready", req_ready, 1'b1);
    quiet_port("a_idle");
    chk("a_mem7", mem[7], 32'hABCD);
    chk("a_mem32", mem[32], 32'h80000004);

    // rs1=0 reads as zero despite reg[0]; write to rd=0 is skipped.
    fetch("b", 5'd0, 5'd7, 32'h0, 32'hABCD);
    retire_op("b");
    wb_valid = 1'b1; wb_en = 1'b1; wb_rd = 5'd0; wb_data = 32'h1234; wb_pc = 32'h80000008;
    step();
    wb_valid = 1'b0;
    chk("b_wpc_wen", rf_wen, 1'b1);
    chk("b_wpc_addr", rf_addr, 6'd32);
    chk("b_wpc_wdata", rf_wdata, 32'h80000008);
    step();
    chk("b_idle_busy", busy, 1'b0);
    quiet_port("b_idle");
    chk("b_mem0", mem[0], 32'hDEAD);
    chk("b_mem32", mem[32], 32'h80000008);

    // rs1==rs2 does two reads; writing rd=rs1 leaves operands alone; reset in WRD.
    fetch("c", 5'd5, 5'd5, 32'h11, 32'h11);
    retire_op("c");
    wb_valid = 1'b1; wb_en = 1'b1; wb_rd = 5'd5; wb_data = 32'h55; wb_pc = 32'h8000000C;
    step();
    wb_valid = 1'b0;
    chk("c_wrd_wen", rf_wen, 1'b1);
    chk("c_wrd_addr", rf_addr, 6'd5);
    chk("c_wrd_rs1", op_rs1_val, 32'h11);
    rst = 1'b1;
    #1;
    quiet_port("c_rst_wrd");
    step();
    chk("c_rst_busy", busy, 1'b0);
    chk("c_rst_req_ready", req_ready, 1'b0);
    chk("c_rst_opv", op_valid, 1'b0);
    quiet_port("c_rst_idle");
    rst = 1'b0;
    #1;
    chk("c_post_req_ready", req_ready, 1'b1);
    chk("c_post_rs1", op_rs1_val, 32'd0);
    step();
    chk("c_mem32", mem[32], 32'h80000008);
    chk("c_mem5", mem[5], 32'h11);
    chk("c_idle_busy", busy, 1'b0);
    quiet_port("c_idle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_seq.md
REGFILE_SEQ -- requirements
Module: regfile_seq

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 6, register-file address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, register data width.
REQ-003 SHALL have parameter PC_ADDR, default 32, register-file index holding the PC.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have ports req_valid input 1, req_ready output 1, req_rs1 input 5, req_rs2 input 5: operand-fetch request.
REQ-007 SHALL have ports op_valid output 1, op_ready input 1, op_rs1_val output DATA_WIDTH, op_rs2_val output DATA_WIDTH: operands to execute.
REQ-008 SHALL have ports wb_valid input 1, wb_ready output 1, wb_en input 1, wb_rd input 5, wb_data input DATA_WIDTH, wb_pc input DATA_WIDTH: writeback and next PC.
REQ-009 SHALL have ports rf_addr output ADDR_WIDTH, rf_wen output 1, rf_ren output 1, rf_wdata output DATA_WIDTH, rf_rdata input DATA_WIDTH: single register-file port.
REQ-010 SHALL have port busy output 1, high whenever state is not IDLE.

Function
REQ-011 SHALL implement states IDLE, RD1, RD2, CAP2, OPV, WBW, WRD, WPC.
REQ-012 SHALL treat rf_rdata as valid in the cycle after the cycle rf_ren was high.
REQ-013 IDLE: req_ready=1; on req_valid&req_ready, SHALL latch rs1/rs2 and go to RD1.
REQ-014 RD1: SHALL drive rf_ren=1, rf_addr={0,rs1}; next RD2.
REQ-015 RD2: SHALL drive rf_ren=1, rf_addr={0,rs2}, capture rf_rdata into rs1 value; next CAP2.
REQ-016 CAP2: SHALL capture rf_rdata into rs2 value; next OPV.
REQ-017 SHALL substitute 0 for a captured operand whose index is 0, regardless of rf_rdata.
REQ-018 OPV: op_valid=1 with operands stable; SHALL hold until op_ready, then go to WBW.
REQ-019 WBW: wb_ready=1; on wb_valid SHALL latch wb_en/wb_rd/wb_data/wb_pc; next WRD if wb_en=1 and wb_rd!=0, else WPC.
REQ-020 WRD: SHALL drive rf_wen=1, rf_addr={0,wb_rd}, rf_wdata=latched wb_data; next WPC.
REQ-021 WPC: SHALL drive rf_wen=1, rf_addr=PC_ADDR, rf_wdata=latched wb_pc; next IDLE.
REQ-022 SHALL never assert rf_wen and rf_ren in the same cycle.
REQ-023 SHALL drive rf_ren=0, rf_wen=0 in every state other than RD1/RD2/WRD/WPC.
REQ-024 SHALL drive rf_addr=0 and rf_wdata=0 when neither rf_wen nor rf_ren is high.
REQ-025 Fixed latency: request accept to op_valid = 3 cycles; wb accept to IDLE = 2 cycles (1 when write to rd is skipped).
REQ-026 req_ready SHALL be 0 outside IDLE; wb_ready SHALL be 0 outside WBW; inputs ignored then.
REQ-027 rs1==rs2 SHALL still perform two reads, both results equal.
REQ-028 Writes to index 0 SHALL never be issued; a write to rd equal to rs1/rs2 of the same instruction SHALL not alter returned operands.

Reset
REQ-029 On rst=1 at posedge SHALL go to IDLE from any state, abandoning any transaction; no rf_wen pulse after the reset edge.
REQ-030 While rst=1 and after it: req_ready=1 (once rst=0), op_valid=0, wb_ready=0, busy=0, rf_wen=0, rf_ren=0, rf_addr=0, rf_wdata=0, operand registers 0.
REQ-031 During rst=1, req_ready SHALL be 0.

Verification
REQ-032 x5=0x11, x6=0x22; request rs1=5, rs2=6 -> RD1 addr 5, RD2 addr 6, op_valid 3 cycles after accept with 0x11/0x22.
REQ-033 rs1=0 with reg[0] preloaded 0xDEAD -> op_rs1_val=0.
REQ-034 op_ready held low 4 cycles -> op_valid and operands stable 4 cycles, no rf activity.
REQ-035 wb_en=1, rd=7, data=0xABCD, pc=0x80000004 -> rf_wen at addr 7 with 0xABCD, next cycle addr 32 with 0x80000004, then IDLE.
REQ-036 wb_en=1, rd=0, pc=0x80000008 -> single rf_wen at addr 32 only; reg[0] unchanged.
REQ-037 rst asserted in WRD -> next cycle IDLE, rf_wen=0, PC register not written.
